// File: rtl/core_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// core_ctrl_fsm
//   Multi-cycle sequencer for the rv32 core. Holds the PC and the instruction
//   register that feeds decode, steps each instruction through
//   FETCH -> DECODE -> EXEC -> (MEM) -> WB, handshakes with instruction and data
//   memory, gates regfile writes and halts on ecall/ebreak or a misaligned PC.
//
//   Optional feature macro: CORE_CTRL_PERF_CNT_EN
//     defined     : cycle_cnt counts non-HALT cycles, instret_cnt counts retires
//     not defined : both counter ports are tied to zero, no counter flops
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   imem_req/imem_addr         fetch request (held until ack), address = pc
//   imem_ack/imem_rdata        fetch completion and instruction word
//   inst, pc                   instruction register and PC, feed decode
//   dec_*                      decode control flags, sampled in the cycle of use
//   branch_target/branch_taken redirect target and branch condition result
//   dmem_req/dmem_we/dmem_ack  data access handshake (we: 1 store, 0 load)
//   rf_we                      regfile write strobe
//   retire                     one pulse per completed instruction
//   halted/halt_cause          sticky halt flag, cause 00 ecall 01 ebreak 10 misaligned
//   cycle_cnt/instret_cnt      performance counters
// -----------------------------------------------------------------------------
module core_ctrl_fsm #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          CNT_W    = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      inst,
   output logic [31:0]      pc,
   input  logic             dec_mem_read,
   input  logic             dec_mem_write,
   input  logic             dec_reg_write,
   input  logic             dec_branch,
   input  logic             dec_jump,
   input  logic             dec_ecall,
   input  logic             dec_ebreak,
   input  logic [31:0]      branch_target,
   input  logic             branch_taken,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ack,
   output logic             rf_we,
   output logic             retire,
   output logic             halted,
   output logic [1:0]       halt_cause,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_nxt;
   logic [31:0] inst_nxt;
   logic        halted_nxt;
   logic [1:0]  cause_nxt;
   logic [31:0] npc;
   logic        redirect;

   assign imem_addr = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_FETCH;
         pc         <= RESET_PC;
         inst       <= NOP_INST;
         halted     <= 1'b0;
         halt_cause <= 2'b00;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         inst       <= inst_nxt;
         halted     <= halted_nxt;
         halt_cause <= cause_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      inst_nxt   = inst;
      halted_nxt = halted;
      cause_nxt  = halt_cause;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      rf_we      = 1'b0;
      retire     = 1'b0;
      redirect   = dec_jump | (dec_branch & branch_taken);
      // pc + 4 wraps naturally in 32 bits
      npc        = redirect ? branch_target : (pc + 32'd4);

      case (state)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               inst_nxt  = imem_rdata;
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            if (dec_ecall || dec_ebreak) begin
               state_nxt  = S_HALT;
               halted_nxt = 1'b1;
               // ecall takes priority when both flags are raised
               cause_nxt  = dec_ecall ? 2'b00 : 2'b01;
            end else begin
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            state_nxt = (dec_mem_read || dec_mem_write) ? S_MEM : S_WB;
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = dec_mem_write;
            if (dmem_ack) state_nxt = S_WB;
         end
         S_WB: begin
            rf_we  = dec_reg_write;
            retire = 1'b1;
            if (npc[1:0] != 2'b00) begin
               // misaligned target: keep the faulting instruction's PC visible
               state_nxt  = S_HALT;
               halted_nxt = 1'b1;
               cause_nxt  = 2'b10;
            end else begin
               pc_nxt    = npc;
               state_nxt = S_FETCH;
            end
         end
         S_HALT: begin
            state_nxt = S_HALT;
         end
         default: begin
            state_nxt = S_HALT;
         end
      endcase
   end

`ifdef CORE_CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_q;
   logic [CNT_W-1:0] instret_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         if (state != S_HALT) cycle_q <= cycle_q + CNT_W'(1);
         if (retire)          instret_q <= instret_q + CNT_W'(1);
      end
   end

   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_core_ctrl_fsm.sv
module tb_core_ctrl_fsm;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam int          CNT_W    = 64;
`ifdef CORE_CTRL_PERF_CNT_EN
   localparam int PERF = 1;
`else
   localparam int PERF = 0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             imem_req;
   logic [31:0]      imem_addr;
   logic             imem_ack = 1'b0;
   logic [31:0]      imem_rdata = 32'h0;
   logic [31:0]      inst;
   logic [31:0]      pc;
   logic             dec_mem_read = 1'b0;
   logic             dec_mem_write = 1'b0;
   logic             dec_reg_write = 1'b0;
   logic             dec_branch = 1'b0;
   logic             dec_jump = 1'b0;
   logic             dec_ecall = 1'b0;
   logic             dec_ebreak = 1'b0;
   logic [31:0]      branch_target = 32'h0;
   logic             branch_taken = 1'b0;
   logic             dmem_req;
   logic             dmem_we;
   logic             dmem_ack = 1'b0;
   logic             rf_we;
   logic             retire;
   logic             halted;
   logic [1:0]       halt_cause;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] instret_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   core_ctrl_fsm #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst(inst), .pc(pc),
      .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write), .dec_reg_write(dec_reg_write),
      .dec_branch(dec_branch), .dec_jump(dec_jump), .dec_ecall(dec_ecall), .dec_ebreak(dec_ebreak),
      .branch_target(branch_target), .branch_taken(branch_taken),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .rf_we(rf_we), .retire(retire), .halted(halted), .halt_cause(halt_cause),
      .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   always #5 clk = ~clk;

   // One rising edge; inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic set_dec(input logic rd, input logic wr, input logic rw, input logic br,
                          input logic jp, input logic ec, input logic eb,
                          input logic [31:0] tgt, input logic tk);
      dec_mem_read = rd; dec_mem_write = wr; dec_reg_write = rw; dec_branch = br;
      dec_jump = jp; dec_ecall = ec; dec_ebreak = eb; branch_target = tgt; branch_taken = tk;
   endtask

   // Zero-wait fetch of one word: leaves the FSM in DECODE.
   task automatic fetch_word(input logic [31:0] w);
      imem_ack = 1'b1; imem_rdata = w;
      step();
      imem_ack = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      set_dec(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_imem_req: got %b want 1", imem_req); end
      n_checks++; if (pc !== RESET_PC) begin n_fail++; $display("FAIL rst_pc: got %h want %h", pc, RESET_PC); end
      n_checks++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL rst_imem_addr: got %h want %h", imem_addr, RESET_PC); end
      n_checks++; if (inst !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_inst: got %h want 00000013", inst); end
      n_checks++; if ({halted, halt_cause} !== 3'b000) begin n_fail++; $display("FAIL rst_halt: got %b%b want 000", halted, halt_cause); end
      n_checks++; if ({dmem_req, rf_we, retire} !== 3'b000) begin n_fail++; $display("FAIL rst_strobes: got %b%b%b want 000", dmem_req, rf_we, retire); end
      n_checks++; if (cycle_cnt !== '0 || instret_cnt !== '0) begin n_fail++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", cycle_cnt, instret_cnt); end
      rst_n = 1'b1;
   endtask

   task automatic test_addi();
      set_dec(0, 0, 1, 0, 0, 0, 0, 32'h0, 0);
      fetch_word(32'h0010_0093);
      n_checks++; if (inst !== 32'h0010_0093) begin n_fail++; $display("FAIL addi_inst: got %h want 00100093", inst); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL addi_dec_imem_req: got %b want 0", imem_req); end
      step();
      n_checks++; if ({rf_we, retire} !== 2'b00) begin n_fail++; $display("FAIL addi_exec_strobes: got %b%b want 00", rf_we, retire); end
      step();
      n_checks++; if ({rf_we, retire} !== 2'b11) begin n_fail++; $display("FAIL addi_wb_strobes: got %b%b want 11", rf_we, retire); end
      n_checks++; if (pc !== RESET_PC) begin n_fail++; $display("FAIL addi_wb_pc: got %h want %h", pc, RESET_PC); end
      step();
      n_checks++; if ({rf_we, retire} !== 2'b00) begin n_fail++; $display("FAIL addi_after_strobes: got %b%b want 00", rf_we, retire); end
      n_checks++; if (pc !== 32'h8000_0004) begin n_fail++; $display("FAIL addi_pc: got %h want 80000004", pc); end
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL addi_refetch: got %b want 1", imem_req); end
      n_checks++; if (cycle_cnt !== CNT_W'(4 * PERF)) begin n_fail++; $display("FAIL addi_cycle_cnt: got %0d want %0d", cycle_cnt, 4 * PERF); end
      n_checks++; if (instret_cnt !== CNT_W'(PERF)) begin n_fail++; $display("FAIL addi_instret_cnt: got %0d want %0d", instret_cnt, PERF); end
   endtask

   task automatic test_fetch_wait();
      set_dec(0, 0, 1, 0, 0, 0, 0, 32'h0, 0);
      imem_rdata = 32'h0020_0113;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL fwait_req_%0d: got %b/%h want 1/80000004", i, imem_req, imem_addr); end
         n_checks++; if (inst !== 32'h0010_0093) begin n_fail++; $display("FAIL fwait_inst_%0d: got %h want 00100093", i, inst); end
         step();
      end
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL fwait_req_3: got %b want 1", imem_req); end
      fetch_word(32'h0020_0113);
      n_checks++; if (inst !== 32'h0020_0113) begin n_fail++; $display("FAIL fwait_inst_ack: got %h want 00200113", inst); end
      step(); step(); step();
      n_checks++; if (pc !== 32'h8000_0008) begin n_fail++; $display("FAIL fwait_pc: got %h want 80000008", pc); end
   endtask

   task automatic test_load();
      set_dec(1, 0, 1, 0, 0, 0, 0, 32'h0, 0);
      fetch_word(32'h0000_a183);
      step();
      n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL lw_exec_dreq: got %b want 0", dmem_req); end
      step();
      for (int i = 0; i < 3; i++) begin
         n_checks++; if ({dmem_req, dmem_we, rf_we} !== 3'b100) begin n_fail++; $display("FAIL lw_mem_%0d: got %b%b%b want 100", i, dmem_req, dmem_we, rf_we); end
         if (i == 2) dmem_ack = 1'b1;
         step();
      end
      dmem_ack = 1'b0;
      n_checks++; if ({dmem_req, rf_we, retire} !== 3'b011) begin n_fail++; $display("FAIL lw_wb: got %b%b%b want 011", dmem_req, rf_we, retire); end
      step();
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_000C) begin n_fail++; $display("FAIL lw_next_fetch: got %b/%h want 1/8000000c", imem_req, imem_addr); end
   endtask

   task automatic test_branch_store();
      set_dec(0, 0, 0, 1, 0, 0, 0, 32'h8000_0040, 1);
      fetch_word(32'h0000_0463);
      step(); step();
      n_checks++; if ({rf_we, retire} !== 2'b01) begin n_fail++; $display("FAIL beq_wb: got %b%b want 01", rf_we, retire); end
      step();
      n_checks++; if (pc !== 32'h8000_0040) begin n_fail++; $display("FAIL beq_taken_pc: got %h want 80000040", pc); end
      set_dec(0, 0, 0, 1, 0, 0, 0, 32'h8000_0080, 0);
      fetch_word(32'h0000_0463);
      step(); step(); step();
      n_checks++; if (pc !== 32'h8000_0044) begin n_fail++; $display("FAIL beq_not_taken_pc: got %h want 80000044", pc); end
      set_dec(0, 1, 0, 0, 0, 0, 0, 32'h0, 0);
      fetch_word(32'h0020_a023);
      step(); step();
      n_checks++; if ({dmem_req, dmem_we} !== 2'b11) begin n_fail++; $display("FAIL sw_mem: got %b%b want 11", dmem_req, dmem_we); end
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      n_checks++; if ({rf_we, retire} !== 2'b01) begin n_fail++; $display("FAIL sw_wb: got %b%b want 01", rf_we, retire); end
      step();
      n_checks++; if (pc !== 32'h8000_0048) begin n_fail++; $display("FAIL sw_pc: got %h want 80000048", pc); end
   endtask

   task automatic test_misaligned();
      set_dec(0, 0, 1, 0, 1, 0, 0, 32'h8000_0042, 0);
      fetch_word(32'h0000_006f);
      step(); step();
      n_checks++; if (retire !== 1'b1) begin n_fail++; $display("FAIL jmp_wb_retire: got %b want 1", retire); end
      step();
      n_checks++; if ({halted, halt_cause} !== 3'b110) begin n_fail++; $display("FAIL jmp_halt: got %b%b want 110", halted, halt_cause); end
      n_checks++; if (pc !== 32'h8000_0048) begin n_fail++; $display("FAIL jmp_pc: got %h want 80000048", pc); end
      imem_ack = 1'b1; imem_rdata = 32'hdead_beef;
      step(); step();
      imem_ack = 1'b0;
      n_checks++; if ({imem_req, dmem_req, rf_we, halted} !== 4'b0001) begin n_fail++; $display("FAIL jmp_sticky: got %b%b%b%b want 0001", imem_req, dmem_req, rf_we, halted); end
      n_checks++; if (inst !== 32'h0000_006f) begin n_fail++; $display("FAIL jmp_inst_frozen: got %h want 0000006f", inst); end
   endtask

   task automatic test_system_halt();
      do_reset();
      set_dec(0, 0, 0, 0, 0, 0, 1, 32'h0, 0);
      fetch_word(32'h0010_0073);
      step();
      n_checks++; if ({halted, halt_cause} !== 3'b101) begin n_fail++; $display("FAIL ebreak_halt: got %b%b want 101", halted, halt_cause); end
      step(); step(); step();
      n_checks++; if ({imem_req, retire} !== 2'b00) begin n_fail++; $display("FAIL ebreak_no_req: got %b%b want 00", imem_req, retire); end
      n_checks++; if (pc !== RESET_PC || inst !== 32'h0010_0073) begin n_fail++; $display("FAIL ebreak_frozen: got %h/%h want %h/00100073", pc, inst, RESET_PC); end
      n_checks++; if (cycle_cnt !== CNT_W'(2 * PERF) || instret_cnt !== '0) begin n_fail++; $display("FAIL ebreak_cnt: got %0d/%0d want %0d/0", cycle_cnt, instret_cnt, 2 * PERF); end
      do_reset();
      set_dec(0, 0, 0, 0, 0, 1, 1, 32'h0, 0);
      fetch_word(32'h0000_0073);
      step();
      n_checks++; if ({halted, halt_cause} !== 3'b100) begin n_fail++; $display("FAIL ecall_priority: got %b%b want 100", halted, halt_cause); end
   endtask

   task automatic test_reset_mid_mem();
      do_reset();
      set_dec(1, 0, 1, 0, 0, 0, 0, 32'h0, 0);
      fetch_word(32'h0000_a183);
      step(); step();
      n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rmem_pending: got %b want 1", dmem_req); end
      rst_n = 1'b0;
      #1;
      n_checks++; if ({dmem_req, imem_req} !== 2'b01) begin n_fail++; $display("FAIL rmem_async_drop: got %b%b want 01", dmem_req, imem_req); end
      dmem_ack = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      dmem_ack = 1'b0;
      n_checks++; if ({imem_req, dmem_req, rf_we, retire} !== 4'b1000) begin n_fail++; $display("FAIL rmem_stale_ack: got %b%b%b%b want 1000", imem_req, dmem_req, rf_we, retire); end
      n_checks++; if (imem_addr !== RESET_PC || inst !== 32'h0000_0013) begin n_fail++; $display("FAIL rmem_restart: got %h/%h want %h/00000013", imem_addr, inst, RESET_PC); end
      n_checks++; if (cycle_cnt !== CNT_W'(PERF) || instret_cnt !== '0) begin n_fail++; $display("FAIL rmem_cnt: got %0d/%0d want %0d/0", cycle_cnt, instret_cnt, PERF); end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_fetch_wait();
      test_load();
      test_branch_store();
      test_misaligned();
      test_system_halt();
      test_reset_mid_mem();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
